// File: rtl/gpr_file_mp.sv
// gpr_file_mp: parametrised multi-port general-purpose register file.
//
// Configurable read/write port counts, register count and data width. Reads may
// be combinational or registered; optional same-cycle write-to-read bypass.
// Colliding writes resolve to the highest port number and raise a one-cycle
// conflict pulse. A sequential clear engine zeroes the array one entry per
// cycle, after reset release and/or on request.
//
// Ports:
//   clk_i          clock, rising edge
//   resetb_i       asynchronous active-low reset
//   rd_sel_i       read index per read port
//   rd_en_i        read enable per read port (registered-read mode only)
//   rd_data_o      read data per read port
//   wr_sel_i       write index per write port
//   wr_en_i        write enable per write port
//   wr_data_i      write data per write port
//   clear_req_i    single-cycle request to zero all registers
//   busy_o         clear engine active: writes dropped, reads return 0
//   wr_conflict_o  pulse: two or more valid writes hit one index last cycle

module gpr_file_mp #(
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_RD         = 3,
    parameter int unsigned NUM_WR         = 2,
    parameter bit          READ_REG       = 1'b1,
    parameter bit          BYPASS         = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                                clk_i,
    input  logic                                resetb_i,
    input  logic [NUM_RD-1:0][IDX_W-1:0]        rd_sel_i,
    input  logic [NUM_RD-1:0]                   rd_en_i,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data_o,
    input  logic [NUM_WR-1:0][IDX_W-1:0]        wr_sel_i,
    input  logic [NUM_WR-1:0]                   wr_en_i,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wr_data_i,
    input  logic                                clear_req_i,
    output logic                                busy_o,
    output logic                                wr_conflict_o
);

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             wr_conflict_q, wr_conflict_d;
    logic             busy;

    logic [DATA_WIDTH-1:0]             mem_q [NUM_REGS];
    logic [NUM_WR-1:0]                 wr_ok;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_val;

    // Indices at or above NUM_REGS exist when NUM_REGS is not a power of two.
    function automatic logic in_range(logic [IDX_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    assign busy          = (state_q == StClear);
    assign busy_o        = busy;
    assign wr_conflict_o = wr_conflict_q;

    // A write takes effect only when idle and in range.
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_ok[k] = wr_en_i[k] & ~busy & in_range(wr_sel_i[k]);
        end
    end

    always_comb begin
        wr_conflict_d = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (wr_ok[j] && wr_ok[k] && (wr_sel_i[j] == wr_sel_i[k])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // Clear engine next state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req_i) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                if (32'(ptr_q) == NUM_REGS - 1) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q       <= ResetState;
            ptr_q         <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Storage has no reset; the clear engine zeroes it instead. Later ports
    // overwrite earlier ones, giving highest-port priority on collisions.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem_q[ptr_q] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_ok[k]) begin
                    mem_q[wr_sel_i[k]] <= wr_data_i[k];
                end
            end
        end
    end

    // Read value per port, with optional forwarding of this cycle's writes.
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (!busy && in_range(rd_sel_i[p])) begin
                rd_val[p] = mem_q[rd_sel_i[p]];
                if (BYPASS) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wr_ok[k] && (wr_sel_i[k] == rd_sel_i[p])) begin
                            rd_val[p] = wr_data_i[k];
                        end
                    end
                end
            end
        end
    end

    if (READ_REG) begin : g_rd_reg
        logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_q;

        always_ff @(posedge clk_i or negedge resetb_i) begin
            if (!resetb_i) begin
                rd_data_q <= '0;
            end else begin
                for (int p = 0; p < NUM_RD; p++) begin
                    if (rd_en_i[p]) begin
                        rd_data_q[p] <= rd_val[p];
                    end
                end
            end
        end

        assign rd_data_o = rd_data_q;
    end else begin : g_rd_comb
        logic unused_rd_en;
        assign unused_rd_en = ^rd_en_i;
        assign rd_data_o    = rd_val;
    end

endmodule

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
Parametrised multi-port general-purpose register file: the successor to the fixed 3-read/2-write GPR file. Read and write port counts, register count and data width are configurable. Adds optional registered reads, write-to-read bypass, a deterministic write-collision priority with a conflict flag, and a sequential clear engine that zeroes the array after reset or on request. It sits between the processor's operand-fetch/writeback stages and the register storage.

Parameters:
NUM_REGS, 32, number of registers; need not be a power of two. Derived IDX_W = $clog2(NUM_REGS).
DATA_WIDTH, 32, register width in bits.
NUM_RD, 3, number of read ports, 1..8.
NUM_WR, 2, number of write ports, 1..4.
READ_REG, 1, 0 = combinational read, 1 = registered read with 1-cycle latency.
BYPASS, 1, 1 = same-cycle write data is forwarded to reads of the same index.
CLEAR_ON_RESET, 1, 1 = clear engine runs automatically after reset release.

Ports:
clk  in  1  clock, rising edge
resetb  in  1  asynchronous active-low reset
rd_sel  in  NUM_RD x IDX_W  read index per port
rd_en  in  NUM_RD  read enable per port (used only when READ_REG=1)
rd_data  out  NUM_RD x DATA_WIDTH  read data per port
wr_sel  in  NUM_WR x IDX_W  write index per port
wr_en  in  NUM_WR  write enable per port
wr_data  in  NUM_WR x DATA_WIDTH  write data per port
clear_req  in  1  single-cycle request to zero all registers
busy  out  1  clear engine active; writes ignored, reads return 0
wr_conflict  out  1  registered pulse: two or more enabled writes hit the same index in the previous cycle

Behaviour:
- Reset (resetb=0, asynchronous): rd_data=0, wr_conflict=0, clear pointer=0. State is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE. busy equals CLEAR_ON_RESET. Array contents are not reset directly.
- FSM states: IDLE and CLEAR.
  - CLEAR: each cycle writes 0 to reg[ptr] and increments ptr. After writing NUM_REGS-1, go to IDLE next cycle. The clear takes exactly NUM_REGS cycles; busy=1 throughout.
  - IDLE -> CLEAR on clear_req=1; ptr is set to 0.
  - clear_req during CLEAR is ignored; there is no restart.
  - Reset asserted mid-clear restarts the clear from index 0 (when CLEAR_ON_RESET=1).
- Writes: at a rising clk with busy=0, every port with wr_en[k]=1 writes reg[wr_sel[k]] <= wr_data[k].
  - Same-index collision: the highest port number wins. wr_conflict=1 in the following cycle only.
  - wr_sel >= NUM_REGS: the write is dropped and does not count toward a conflict.
  - Writes while busy=1 are dropped; no conflict is flagged.
- Read value function V(i):
  - busy=1 or i >= NUM_REGS: V = 0.
  - Otherwise, if BYPASS=1 and some enabled, in-range write targets i this cycle: V = that write's data, using the same highest-port priority.
  - Otherwise: V = reg[i].
- READ_REG=0: rd_data[p] = V(rd_sel[p]) combinationally; rd_en is ignored.
- READ_REG=1: at a rising clk, if rd_en[p]=1 then rd_data[p] <= V(rd_sel[p]); otherwise rd_data[p] holds. Latency is 1 cycle.
- With BYPASS=0, a read of an index written in the same cycle returns the old value. The new value is visible from the next cycle.
- All ports are independent; any number of read ports may select the same index.

Test Plan:
- Reset-clear: NUM_REGS=32, CLEAR_ON_RESET=1, release resetb -> busy=1 for exactly 32 cycles; then reading regs 0..31 returns 0; a write issued during busy is lost.
- Basic write/read: write r5=0xDEADBEEF on port 0, then read r5 on all 3 ports with rd_en=1 -> 0xDEADBEEF on every port 1 cycle later (READ_REG=1).
- Bypass: same cycle, write r7=0x1234 and read r7. BYPASS=1 -> 0x1234 after 1 cycle. BYPASS=0 -> old value, then 0x1234 on the following read.
- Collision: ports 0 and 1 both write r3 (0xAAAA, 0x5555) -> r3=0x5555; wr_conflict=1 for one cycle, then 0. Ports 0 and 1 writing r3 and r4 -> wr_conflict stays 0.
- Out of range: NUM_REGS=24, write index 30 -> no state change and no conflict; read index 30 -> 0.
- Mid-clear reset: clear_req at cycle 0, assert resetb=0 at cycle 10, release -> busy=1 for a full 32 cycles from release; clear_req pulsed during CLEAR does not extend busy.
